spawn_allocator: RTL and testbench

SPAWN_ALLOCATOR -- requirements
Module: spawn_allocator

---
 rtl/tabajara_pkg.sv | 17 +
 rtl/occupancy_map.sv | 60 ++++++
 rtl/spawn_allocator.sv | 142 ++++++++++++++
 tb/tb_spawn_allocator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tabajara_pkg.sv
// Shared definitions for the spawn allocator.
//   NUM_CELLS : number of allocatable cells
//   IDX_W     : width of a cell index and of the occupied-cell count
//   state_t   : allocator FSM state encoding
package tabajara_pkg;

    localparam int unsigned NUM_CELLS = 24;
    localparam int unsigned IDX_W     = 5;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        PROBE,
        DONE
    } state_t;

endpackage

// File: rtl/occupancy_map.sv
// Occupied-cell bitmap and population count with same-edge set/free update.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   set_valid, set_idx  : mark a cell occupied at this edge
//   free_valid, free_idx: release a cell at this edge (ignored if empty or out of range)
//   occupancy           : registered occupied-cell bitmap
//   count               : registered number of occupied cells
module occupancy_map #(
    parameter int unsigned NUM_CELLS = tabajara_pkg::NUM_CELLS,
    parameter int unsigned IDX_W     = tabajara_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_valid,
    input  logic [IDX_W-1:0]     set_idx,
    input  logic                 free_valid,
    input  logic [IDX_W-1:0]     free_idx,
    output logic [NUM_CELLS-1:0] occupancy,
    output logic [IDX_W-1:0]     count
);

    import tabajara_pkg::*;

    logic [NUM_CELLS-1:0] set_mask;
    logic [NUM_CELLS-1:0] free_mask;
    logic [NUM_CELLS-1:0] set_eff_mask;
    logic [NUM_CELLS-1:0] free_eff_mask;
    logic [NUM_CELLS-1:0] occupancy_next;
    logic [IDX_W-1:0]     count_next;
    logic                 set_eff;
    logic                 free_eff;

    always_comb begin
        set_mask  = '0;
        free_mask = '0;
        // Decoding by comparison keeps out-of-range indices from aliasing a cell.
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            set_mask[i]  = set_valid  && (set_idx  == IDX_W'(i));
            free_mask[i] = free_valid && (free_idx == IDX_W'(i));
        end
        // A free only counts on an occupied cell that is not being set this edge.
        free_eff_mask  = free_mask & occupancy & ~set_mask;
        set_eff_mask   = set_mask & ~occupancy;
        set_eff        = |set_eff_mask;
        free_eff       = |free_eff_mask;
        occupancy_next = (occupancy & ~free_eff_mask) | set_eff_mask;
        count_next     = count + IDX_W'(set_eff) - IDX_W'(free_eff);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
            count     <= '0;
        end else begin
            occupancy <= occupancy_next;
            count     <= count_next;
        end
    end

endmodule

// File: rtl/spawn_allocator.sv
// Randomised cell allocator: on a request, samples a random start cell and
// linearly probes (with wrap) for a free cell, or reports full.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   rand_in               : random source, low IDX_W bits used
//   req_valid, req_ready  : allocation request handshake
//   free_valid, free_idx  : release a cell (any state)
//   resp_valid            : one-cycle response strobe
//   resp_idx, resp_full   : allocated cell / all-cells-occupied flag, held until next response
//   occupancy, count      : occupied-cell bitmap and population count
module spawn_allocator #(
    parameter int unsigned NUM_CELLS = tabajara_pkg::NUM_CELLS,
    parameter int unsigned IDX_W     = tabajara_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          rand_in,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 free_valid,
    input  logic [IDX_W-1:0]     free_idx,
    output logic                 resp_valid,
    output logic [IDX_W-1:0]     resp_idx,
    output logic                 resp_full,
    output logic [NUM_CELLS-1:0] occupancy,
    output logic [IDX_W-1:0]     count
);

    import tabajara_pkg::*;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] cand_next;
    logic [IDX_W-1:0] probe_cnt;
    logic [IDX_W-1:0] probe_cnt_next;
    logic [IDX_W-1:0] rand_cand;
    logic             resp_valid_next;
    logic [IDX_W-1:0] resp_idx_next;
    logic             resp_full_next;
    logic             set_valid;
    logic             unused_rand_bits;

    assign unused_rand_bits = ^rand_in[31:IDX_W];

    occupancy_map #(
        .NUM_CELLS (NUM_CELLS),
        .IDX_W     (IDX_W)
    ) u_map (
        .clk        (clk),
        .reset      (reset),
        .set_valid  (set_valid),
        .set_idx    (cand),
        .free_valid (free_valid),
        .free_idx   (free_idx),
        .occupancy  (occupancy),
        .count      (count)
    );

    // Fold values past the last cell back into range (24..31 -> 0..7).
    always_comb begin
        rand_cand = rand_in[IDX_W-1:0];
        if (rand_cand >= IDX_W'(NUM_CELLS)) begin
            rand_cand = rand_cand - IDX_W'(NUM_CELLS);
        end
    end

    always_comb begin
        state_next      = state;
        cand_next       = cand;
        probe_cnt_next  = probe_cnt;
        set_valid       = 1'b0;
        resp_valid_next = 1'b0;
        resp_idx_next   = resp_idx;
        resp_full_next  = resp_full;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                cand_next      = rand_cand;
                probe_cnt_next = '0;
                // Full decision uses the pre-edge count; a same-edge free does not rescue it.
                if (count == IDX_W'(NUM_CELLS)) begin
                    state_next      = DONE;
                    resp_valid_next = 1'b1;
                    resp_full_next  = 1'b1;
                end else begin
                    state_next = PROBE;
                end
            end
            PROBE: begin
                if (!occupancy[cand]) begin
                    set_valid       = 1'b1;
                    state_next      = DONE;
                    resp_valid_next = 1'b1;
                    resp_idx_next   = cand;
                    resp_full_next  = 1'b0;
                end else if (probe_cnt == IDX_W'(NUM_CELLS - 1)) begin
                    // Every cell checked without a hit: only reachable if the map
                    // changed under us, so report full rather than spin.
                    state_next      = DONE;
                    resp_valid_next = 1'b1;
                    resp_full_next  = 1'b1;
                end else begin
                    cand_next      = (cand == IDX_W'(NUM_CELLS - 1)) ? '0 : cand + 1'b1;
                    probe_cnt_next = probe_cnt + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cand       <= '0;
            probe_cnt  <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_idx   <= '0;
            resp_full  <= 1'b0;
        end else begin
            state      <= state_next;
            cand       <= cand_next;
            probe_cnt  <= probe_cnt_next;
            req_ready  <= (state_next == IDLE);
            resp_valid <= resp_valid_next;
            resp_idx   <= resp_idx_next;
            resp_full  <= resp_full_next;
        end
    end

endmodule

// File: tb/tb_spawn_allocator.sv
// Self-checking bench for spawn_allocator: table of allocation vectors,
// model-driven fill, and hand-written free/full/reset sequences.
module tb_spawn_allocator;

    localparam int unsigned NC = 24;
    localparam int unsigned IW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   rand_in = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          free_valid = 1'b0;
    logic [IW-1:0] free_idx = '0;
    logic          resp_valid;
    logic [IW-1:0] resp_idx;
    logic          resp_full;
    logic [NC-1:0] occupancy;
    logic [IW-1:0] count;

    always #5 clk = ~clk;

    spawn_allocator #(
        .NUM_CELLS (NC),
        .IDX_W     (IW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rand_in    (rand_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .free_valid (free_valid),
        .free_idx   (free_idx),
        .resp_valid (resp_valid),
        .resp_idx   (resp_idx),
        .resp_full  (resp_full),
        .occupancy  (occupancy),
        .count      (count)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic          full;
    } resp_t;

    typedef struct {
        logic [31:0]   r;
        logic [IW-1:0] idx;
        int            lat;
        logic [NC-1:0] occ;
        logic [IW-1:0] cnt;
    } vec_t;

    resp_t sb_q[$];
    vec_t  tbl[8];
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // One request; free_edge (>0) injects a free taking effect at handshake edge + free_edge.
    task automatic do_req(input logic [31:0] r, input logic [IW-1:0] e_idx, input logic e_full,
                          input int e_lat, input int free_edge, input logic [IW-1:0] f_idx,
                          input logic [NC-1:0] e_occ, input logic [IW-1:0] e_cnt, input string tag);
        int    lat;
        int    waits;
        bit    got;
        resp_t exp_r;
        @(negedge clk);
        rand_in   = r;
        req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, " ready"}, req_ready, 1);
        @(posedge clk);
        sb_q.push_back('{idx: e_idx, full: e_full});
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (free_edge == lat + 1) begin
                free_valid = 1'b1;
                free_idx   = f_idx;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            free_valid = 1'b0;
            if (resp_valid) got = 1'b1;
        end
        chk({tag, " resp_seen"}, got, 1);
        if (sb_q.size() > 0) begin
            exp_r = sb_q.pop_front();
            if (got) begin
                chk({tag, " idx"},  resp_idx, exp_r.idx);
                chk({tag, " full"}, resp_full, exp_r.full);
                chk({tag, " lat"},  lat, e_lat);
                chk({tag, " occ"},  occupancy, e_occ);
                chk({tag, " cnt"},  count, e_cnt);
                @(negedge clk);
                chk({tag, " one_shot"}, resp_valid, 0);
                chk({tag, " ready_back"}, req_ready, 1);
            end
        end
    endtask

    task automatic do_free(input logic [IW-1:0] fi, input logic [NC-1:0] e_occ,
                           input logic [IW-1:0] e_cnt, input string tag);
        @(negedge clk);
        free_valid = 1'b1;
        free_idx   = fi;
        @(negedge clk);
        free_valid = 1'b0;
        chk({tag, " occ"}, occupancy, e_occ);
        chk({tag, " cnt"}, count, e_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NC-1:0] m_occ;
        int            c;
        int            k;

        tbl[0] = '{32'd7,  5'd7,  2, 24'h000080, 5'd1};
        tbl[1] = '{32'd29, 5'd5,  2, 24'h0000A0, 5'd2};
        tbl[2] = '{32'd7,  5'd8,  3, 24'h0001A0, 5'd3};
        tbl[3] = '{32'd23, 5'd23, 2, 24'h8001A0, 5'd4};
        tbl[4] = '{32'd0,  5'd0,  2, 24'h8001A1, 5'd5};
        tbl[5] = '{32'd1,  5'd1,  2, 24'h8001A3, 5'd6};
        tbl[6] = '{32'd23, 5'd2,  5, 24'h8001A7, 5'd7};
        tbl[7] = '{32'd31, 5'd9,  4, 24'h8003A7, 5'd8};

        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst ready", req_ready, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_idx", resp_idx, 0);
        chk("rst resp_full", resp_full, 0);
        chk("rst occ", occupancy, 0);
        chk("rst cnt", count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1 chk("rst ready_low", req_ready, 0);
        @(negedge clk);
        chk("rst ready_rise", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].r, tbl[i].idx, 1'b0, tbl[i].lat, -1, '0, tbl[i].occ, tbl[i].cnt, "tbl");
        end

        // Fill the remaining cells, expectations from a linear-probe model
        m_occ = 24'h8003A7;
        for (int n = 0; n < 16; n++) begin
            c = 0;
            k = 0;
            while (m_occ[c]) begin
                c = (c == NC - 1) ? 0 : c + 1;
                k++;
            end
            m_occ[c] = 1'b1;
            do_req(32'd0, c[IW-1:0], 1'b0, 2 + k, -1, '0, m_occ, 5'(9 + n), "fill");
        end

        do_req(32'd3, 5'd22, 1'b1, 1, -1, '0, 24'hFFFFFF, 5'd24, "full");
        do_req(32'd3, 5'd22, 1'b1, 1, 1, 5'd10, 24'hFFFBFF, 5'd23, "full_free_sample");
        do_req(32'd4, 5'd10, 1'b0, 8, 3, 5'd4, 24'hFFFFEF, 5'd23, "probe_free");
        do_free(5'd25, 24'hFFFFEF, 5'd23, "free_oor");
        do_free(5'd4,  24'hFFFFEF, 5'd23, "free_empty");
        do_req(32'd28, 5'd4, 1'b0, 2, 2, 5'd0, 24'hFFFFFE, 5'd23, "set_free");
        do_req(32'd24, 5'd0, 1'b0, 2, 2, 5'd0, 24'hFFFFFF, 5'd24, "set_same");
        do_free(5'd5, 24'hFFFFDF, 5'd23, "free5");

        // Reset during a long probe (start 6, only cell 5 free)
        @(negedge clk);
        rand_in   = 32'd6;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid rst ready", req_ready, 0);
        chk("mid rst resp_valid", resp_valid, 0);
        chk("mid rst resp_idx", resp_idx, 0);
        chk("mid rst resp_full", resp_full, 0);
        chk("mid rst occ", occupancy, 0);
        chk("mid rst cnt", count, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid rst hold resp_valid", resp_valid, 0);
        end
        reset = 1'b1;
        #1 chk("mid rst ready_low", req_ready, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("post rst no_resp", resp_valid, 0);
        end
        chk("post rst occ", occupancy, 0);
        chk("post rst cnt", count, 0);
        chk("post rst ready", req_ready, 1);

        do_req(32'd7, 5'd7, 1'b0, 2, -1, '0, 24'h000080, 5'd1, "post_rst_alloc");

        chk("sb empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
